// File: rtl/led_pwm_pkg.sv
// rtl/led_pwm_pkg.sv - shared constants and types for the LED PWM engine
// Contents: channel indices (led/red/green/blue), default parameter values,
//           duty_t and a helper sizing the prescaler counter.
package led_pwm_pkg;

    localparam int LED_CH   = 0;
    localparam int RED_CH   = 1;
    localparam int GREEN_CH = 2;
    localparam int BLUE_CH  = 3;

    localparam int CHANNELS_DEFAULT = 4;
    localparam int DUTY_W_DEFAULT   = 8;
    localparam int PRESCALE_DEFAULT = 46;

    typedef logic [DUTY_W_DEFAULT-1:0] duty_t;

    // Prescaler counter width; PRESCALE=0 still needs a 1-bit register.
    function automatic int prescale_width(input int prescale);
        return (prescale > 0) ? $clog2(prescale + 1) : 1;
    endfunction

endpackage

// File: rtl/led_pwm_if.sv
// rtl/led_pwm_if.sv - duty update valid/ready handshake bundle
// Signals: duty_in    packed duties, channel i at [i*DUTY_W +: DUTY_W]
//          duty_valid source offers a duty set
//          duty_ready engine can accept a duty set
// Modports: master (duty source), slave (PWM engine).
interface led_pwm_if #(
    parameter int CHANNELS = 4,
    parameter int DUTY_W   = 8
);
    logic [CHANNELS*DUTY_W-1:0] duty_in;
    logic                       duty_valid;
    logic                       duty_ready;

    modport master (
        output duty_in,
        output duty_valid,
        input  duty_ready
    );

    modport slave (
        input  duty_in,
        input  duty_valid,
        output duty_ready
    );
endinterface

// File: rtl/led_pwm_timebase.sv
// rtl/led_pwm_timebase.sv - prescaler and step counter for the PWM engine
// Ports: clk   system clock
//        reset asynchronous active-low reset
//        tick  step advance strobe, high when the prescaler reaches PRESCALE
//        step  current PWM step, 0 .. 2**DUTY_W-1
//        wrap  tick on the last step of a period (period boundary)
module pwm_timebase
    import led_pwm_pkg::*;
#(
    parameter int DUTY_W   = DUTY_W_DEFAULT,
    parameter int PRESCALE = PRESCALE_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    output logic              tick,
    output logic [DUTY_W-1:0] step,
    output logic              wrap
);

    localparam int              PW         = prescale_width(PRESCALE);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE);
    localparam logic [DUTY_W-1:0] STEP_LAST = '1;

    logic [PW-1:0]     presc_q, presc_d;
    logic [DUTY_W-1:0] step_q,  step_d;

    always_comb begin
        tick    = (presc_q == PRESC_LAST);
        wrap    = tick && (step_q == STEP_LAST);
        presc_d = tick ? '0 : presc_q + 1'b1;
        // Step wraps naturally from all-ones to zero.
        step_d  = tick ? step_q + 1'b1 : step_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
            step_q  <= '0;
        end else begin
            presc_q <= presc_d;
            step_q  <= step_d;
        end
    end

    assign step = step_q;

endmodule

// File: rtl/led_pwm.sv
// rtl/led_pwm.sv - double-buffered multi-channel LED PWM engine
// Ports: clk          system clock
//        reset        asynchronous active-low reset
//        duty_if      slave side of the duty update handshake
//        pwm          active-high PWM outputs, ch0=led ch1=red ch2=green ch3=blue
//        period_start one-cycle pulse in the cycle after each period boundary
module led_pwm
    import led_pwm_pkg::*;
#(
    parameter int CHANNELS = CHANNELS_DEFAULT,
    parameter int DUTY_W   = DUTY_W_DEFAULT,
    parameter int PRESCALE = PRESCALE_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    led_pwm_if.slave            duty_if,
    output logic [CHANNELS-1:0] pwm,
    output logic                period_start
);

    logic              tick_w;
    logic              wrap_w;
    logic [DUTY_W-1:0] step_w;

    pwm_timebase #(
        .DUTY_W   (DUTY_W),
        .PRESCALE (PRESCALE)
    ) u_timebase (
        .clk   (clk),
        .reset (reset),
        .tick  (tick_w),
        .step  (step_w),
        .wrap  (wrap_w)
    );

    logic [CHANNELS*DUTY_W-1:0] pending_q, pending_d;
    logic [CHANNELS*DUTY_W-1:0] active_q,  active_d;
    logic                       pending_flag_q, pending_flag_d;
    logic [CHANNELS-1:0]        pwm_q, pwm_d;
    logic                       period_start_q, period_start_d;
    logic                       boundary;
    logic                       take;

    always_comb begin
        // wrap is only meaningful on a step tick; gating here keeps the
        // boundary definition local to the engine.
        boundary       = tick_w & wrap_w;
        take           = duty_if.duty_valid & ~pending_flag_q;

        pending_d      = pending_q;
        pending_flag_d = pending_flag_q;
        active_d       = active_q;
        pwm_d          = '0;
        period_start_d = boundary;

        // A transfer can only happen with the pending slot empty, so it never
        // coincides with an apply; a transfer on a boundary waits one period.
        if (take) begin
            pending_d      = duty_if.duty_in;
            pending_flag_d = 1'b1;
        end else if (boundary && pending_flag_q) begin
            active_d       = pending_q;
            pending_flag_d = 1'b0;
        end

        for (int i = 0; i < CHANNELS; i++) begin
            pwm_d[i] = (step_w < active_q[i*DUTY_W +: DUTY_W]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q      <= '0;
            active_q       <= '0;
            pending_flag_q <= 1'b0;
            pwm_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            pending_q      <= pending_d;
            active_q       <= active_d;
            pending_flag_q <= pending_flag_d;
            pwm_q          <= pwm_d;
            period_start_q <= period_start_d;
        end
    end

    assign duty_if.duty_ready = ~pending_flag_q;
    assign pwm                = pwm_q;
    assign period_start       = period_start_q;

endmodule

// File: tb/tb_led_pwm.sv
// tb/tb_led_pwm.sv - self-checking bench for led_pwm with PRESCALE=1
module tb_led_pwm;
    import led_pwm_pkg::*;

    localparam int CH     = 4;
    localparam int DW     = 8;
    localparam int PRE    = 1;
    localparam int PERIOD = 512;

    logic          clk = 1'b0;
    logic          reset;
    logic [CH-1:0] pwm;
    logic          period_start;

    led_pwm_if #(.CHANNELS(CH), .DUTY_W(DW)) dif ();

    led_pwm #(
        .CHANNELS (CH),
        .DUTY_W   (DW),
        .PRESCALE (PRE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .duty_if      (dif.slave),
        .pwm          (pwm),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int acc[CH];

    typedef struct {
        logic [CH*DW-1:0] duty;
        int               exp_hi[CH];
    } vec_t;

    vec_t vecs[3];

    function automatic logic [CH*DW-1:0] pack(input duty_t led, input duty_t red,
                                              input duty_t green, input duty_t blue);
        logic [CH*DW-1:0] p;
        p = '0;
        p[LED_CH*DW   +: DW] = led;
        p[RED_CH*DW   +: DW] = red;
        p[GREEN_CH*DW +: DW] = green;
        p[BLUE_CH*DW  +: DW] = blue;
        return p;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_acc();
        for (int c = 0; c < CH; c++) acc[c] = 0;
    endtask

    // Sample pwm at the current falling edge, then advance one clock.
    task automatic tick_n(input int n);
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < CH; c++) if (pwm[c]) acc[c]++;
            @(negedge clk);
        end
    endtask

    task automatic chk_acc(input string name, input int e0, input int e1,
                           input int e2, input int e3);
        chk($sformatf("%s_ch0", name), acc[0], e0);
        chk($sformatf("%s_ch1", name), acc[1], e1);
        chk($sformatf("%s_ch2", name), acc[2], e2);
        chk($sformatf("%s_ch3", name), acc[3], e3);
    endtask

    task automatic wait_ps(input string name);
        int k;
        k = 0;
        while (!period_start && k < 1100) begin
            tick_n(1);
            k++;
        end
        chk(name, int'(period_start), 1);
    endtask

    task automatic send(input logic [CH*DW-1:0] d);
        int k;
        k = 0;
        while (!dif.duty_ready && k < 1100) begin
            tick_n(1);
            k++;
        end
        chk("send_ready", int'(dif.duty_ready), 1);
        dif.duty_in    = d;
        dif.duty_valid = 1'b1;
        tick_n(1);
        dif.duty_valid = 1'b0;
    endtask

    task automatic ps_latency(input string name);
        int cnt;
        cnt = 0;
        while (cnt < 2000) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            if (period_start) break;
        end
        chk(name, cnt, PERIOD);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CH*DW-1:0] a_set;
        logic [CH*DW-1:0] b_set;
        logic [CH*DW-1:0] c_set;
        int ready_hi;

        vecs[0].duty   = pack(8'd0, 8'd255, 8'd1, 8'd128);
        vecs[0].exp_hi = '{0, 510, 2, 256};
        vecs[1].duty   = pack(8'd200, 8'd3, 8'd254, 8'd17);
        vecs[1].exp_hi = '{400, 6, 508, 34};
        vecs[2].duty   = pack(8'd64, 8'd128, 8'd32, 8'd255);
        vecs[2].exp_hi = '{128, 256, 64, 510};

        a_set = pack(8'd10, 8'd20, 8'd30, 8'd40);
        b_set = pack(8'd50, 8'd60, 8'd70, 8'd80);
        c_set = pack(8'd255, 8'd0, 8'd100, 8'd1);

        // Reset values and first period_start latency
        dif.duty_valid = 1'b0;
        dif.duty_in    = '0;
        reset          = 1'b0;
        repeat (5) @(negedge clk);
        chk("reset_pwm", int'(pwm), 0);
        chk("reset_ready", int'(dif.duty_ready), 1);
        chk("reset_ps", int'(period_start), 0);
        reset = 1'b1;
        ps_latency("first_ps_latency");

        // Table: load, wait for the apply boundary, measure one full period
        for (int v = 0; v < 3; v++) begin
            send(vecs[v].duty);
            wait_ps($sformatf("vec%0d_apply_ps", v));
            clear_acc();
            tick_n(PERIOD);
            chk_acc($sformatf("vec%0d_hi", v), vecs[v].exp_hi[0], vecs[v].exp_hi[1],
                    vecs[v].exp_hi[2], vecs[v].exp_hi[3]);
            chk($sformatf("vec%0d_next_ps", v), int'(period_start), 1);
        end

        // Boundary-only update: ch0 64 -> 200 mid-period
        clear_acc();
        tick_n(1);
        chk("ps_one_cycle", int'(period_start), 0);
        tick_n(99);
        dif.duty_in    = pack(8'd200, 8'd128, 8'd32, 8'd255);
        dif.duty_valid = 1'b1;
        tick_n(1);
        dif.duty_valid = 1'b0;
        chk("bnd_ready_low", int'(dif.duty_ready), 0);
        tick_n(411);
        chk("bnd_ps", int'(period_start), 1);
        chk("bnd_old_ch0", acc[0], 128);
        clear_acc();
        tick_n(PERIOD);
        chk_acc("bnd_new", 400, 256, 64, 510);

        // Backpressure: two back-to-back transfers
        clear_acc();
        tick_n(10);
        dif.duty_in    = a_set;
        dif.duty_valid = 1'b1;
        tick_n(1);
        chk("bp_ready_after_first", int'(dif.duty_ready), 0);
        dif.duty_in = b_set;
        ready_hi = 0;
        for (int k = 0; k < 500; k++) begin
            if (dif.duty_ready) ready_hi++;
            tick_n(1);
        end
        chk("bp_ready_held_low", ready_hi, 0);
        chk("bp_ready_wrap_cycle", int'(dif.duty_ready), 0);
        tick_n(1);
        chk("bp_ps", int'(period_start), 1);
        chk("bp_ready_after_wrap", int'(dif.duty_ready), 1);
        chk_acc("bp_old", 400, 256, 64, 510);
        clear_acc();
        tick_n(1);
        chk("bp_second_taken", int'(dif.duty_ready), 0);
        dif.duty_valid = 1'b0;
        tick_n(PERIOD - 1);
        chk_acc("bp_first", 20, 40, 60, 80);
        clear_acc();
        tick_n(PERIOD);
        chk_acc("bp_second", 100, 120, 140, 160);

        // Transfer exactly on the wrap cycle
        clear_acc();
        tick_n(PERIOD - 1);
        chk("wrap_ready", int'(dif.duty_ready), 1);
        dif.duty_in    = c_set;
        dif.duty_valid = 1'b1;
        tick_n(1);
        dif.duty_valid = 1'b0;
        chk("wrap_ps", int'(period_start), 1);
        chk("wrap_captured", int'(dif.duty_ready), 0);
        chk_acc("wrap_prev", 100, 120, 140, 160);
        clear_acc();
        tick_n(PERIOD);
        chk_acc("wrap_not_yet", 100, 120, 140, 160);
        clear_acc();
        tick_n(PERIOD);
        chk_acc("wrap_applied", 510, 0, 200, 2);

        // Async reset mid-period with a duty set pending
        tick_n(5);
        dif.duty_in    = pack(8'd0, 8'd255, 8'd0, 8'd0);
        dif.duty_valid = 1'b1;
        tick_n(1);
        dif.duty_valid = 1'b0;
        chk("ar_pending", int'(dif.duty_ready), 0);
        tick_n(20);
        chk("ar_pwm_before", int'(pwm), 5);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_pwm", int'(pwm), 0);
        chk("ar_ready", int'(dif.duty_ready), 1);
        chk("ar_ps", int'(period_start), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        ps_latency("ar_ps_latency");
        clear_acc();
        tick_n(PERIOD);
        chk_acc("ar_active_zero", 0, 0, 0, 0);
        chk("ar_next_ps", int'(period_start), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
